// File: rtl/nios2_mult_pipe.sv
// Two-stage pipelined DATA_W x DATA_W multiplier: S1 registers four half-width partial
// products, S2 sums them and registers the result. High-word ops need NIOS2_MULT_HIGH_WORD_EN.
module nios2_mult_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_op,
    input  logic              E_valid,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_mul_result,
    output logic              M_mul_valid
);
    localparam int HALF = DATA_W / 2;
    localparam int PPW  = DATA_W + 2;   // signed (HALF+1) x (HALF+1) product width
    localparam int PW   = 2 * DATA_W;

    logic a_sgn, b_sgn, op_hi;
`ifdef NIOS2_MULT_HIGH_WORD_EN
    assign a_sgn = E_op[1];
    assign b_sgn = &E_op;
    assign op_hi = |E_op;
`else
    logic unused_op;
    assign unused_op = ^E_op;
    assign a_sgn = 1'b0;
    assign b_sgn = 1'b0;
    assign op_hi = 1'b0;
`endif

    // Operand split: low halves unsigned, high chunks HALF+1 bits carrying the extension bit
    logic [HALF-1:0]         a_lo, b_lo;
    logic [HALF:0]           a_hi, b_hi;
    logic signed [PPW-1:0]   a_lo_x, b_lo_x, a_hi_x, b_hi_x;

    assign a_lo   = E_src1[HALF-1:0];
    assign b_lo   = E_src2[HALF-1:0];
    assign a_hi   = {a_sgn & E_src1[DATA_W-1], E_src1[DATA_W-1:HALF]};
    assign b_hi   = {b_sgn & E_src2[DATA_W-1], E_src2[DATA_W-1:HALF]};
    assign a_lo_x = {{(HALF+2){1'b0}}, a_lo};
    assign b_lo_x = {{(HALF+2){1'b0}}, b_lo};
    assign a_hi_x = {{(HALF+1){a_hi[HALF]}}, a_hi};
    assign b_hi_x = {{(HALF+1){b_hi[HALF]}}, b_hi};

    logic [DATA_W-1:0]     pp_ll_d, pp_ll_q;
    logic signed [PPW-1:0] pp_lh_d, pp_lh_q, pp_hl_d, pp_hl_q;

    assign pp_ll_d = {{HALF{1'b0}}, a_lo} * {{HALF{1'b0}}, b_lo};
    assign pp_lh_d = a_lo_x * b_hi_x;
    assign pp_hl_d = a_hi_x * b_lo_x;

`ifdef NIOS2_MULT_HIGH_WORD_EN
    logic signed [PPW-1:0] pp_hh_d, pp_hh_q;
    assign pp_hh_d = a_hi_x * b_hi_x;
`endif

    logic              s1_hi;
    logic [2:1]        vld_pipe;
    logic [DATA_W-1:0] res_q;

    // S2 adder: signed partial products sign-extended into the 2*DATA_W sum
    logic [PW-1:0]     lh_x, hl_x, p;
    logic [DATA_W-1:0] res_d;

    assign lh_x = {{(PW-PPW){pp_lh_q[PPW-1]}}, pp_lh_q};
    assign hl_x = {{(PW-PPW){pp_hl_q[PPW-1]}}, pp_hl_q};
`ifdef NIOS2_MULT_HIGH_WORD_EN
    logic [PW-1:0] hh_x;
    assign hh_x = {{(PW-PPW){pp_hh_q[PPW-1]}}, pp_hh_q};
    assign p    = {{DATA_W{1'b0}}, pp_ll_q} + (lh_x << HALF) + (hl_x << HALF) + (hh_x << DATA_W);
`else
    assign p    = {{DATA_W{1'b0}}, pp_ll_q} + (lh_x << HALF) + (hl_x << HALF);
`endif
    assign res_d = s1_hi ? p[PW-1:DATA_W] : p[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_ll_q  <= '0;
            pp_lh_q  <= '0;
            pp_hl_q  <= '0;
`ifdef NIOS2_MULT_HIGH_WORD_EN
            pp_hh_q  <= '0;
`endif
            s1_hi    <= 1'b0;
            res_q    <= '0;
            vld_pipe <= '0;
        end else begin
            if (M_en) begin
                pp_ll_q <= pp_ll_d;
                pp_lh_q <= pp_lh_d;
                pp_hl_q <= pp_hl_d;
`ifdef NIOS2_MULT_HIGH_WORD_EN
                pp_hh_q <= pp_hh_d;
`endif
                s1_hi   <= op_hi;
                res_q   <= res_d;
            end
            // Flush beats both stall and a new operand on the same edge
            if (M_flush)
                vld_pipe <= '0;
            else if (M_en)
                vld_pipe <= {vld_pipe[1], E_valid};
        end
    end

    assign M_mul_result = res_q;
    assign M_mul_valid  = vld_pipe[2];

endmodule

// File: tb/tb_nios2_mult_pipe.sv
// Directed bench for nios2_mult_pipe at DATA_W=32, plus a small random sweep at 8/16/32.
module tb_nios2_mult_pipe;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [1:0]  op = '0;
    logic        vld = 1'b0, en = 1'b1, flush = 1'b0;
    logic [31:0] r32;
    logic [15:0] r16;
    logic [7:0]  r8;
    logic        v32, v16, v8;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    nios2_mult_pipe #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .E_src1(src1), .E_src2(src2), .E_op(op),
        .E_valid(vld), .M_en(en), .M_flush(flush), .M_mul_result(r32), .M_mul_valid(v32));
    nios2_mult_pipe #(.DATA_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .E_src1(src1[15:0]), .E_src2(src2[15:0]), .E_op(op),
        .E_valid(vld), .M_en(en), .M_flush(flush), .M_mul_result(r16), .M_mul_valid(v16));
    nios2_mult_pipe #(.DATA_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .E_src1(src1[7:0]), .E_src2(src2[7:0]), .E_op(op),
        .E_valid(vld), .M_en(en), .M_flush(flush), .M_mul_result(r8), .M_mul_valid(v8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation; it is captured by the next edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        src1 = a; src2 = b; op = o; vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [31:0] exp);
        issue(a, b, o);
        chk({tag, "_early"}, 64'(v32), 64'd0);
        step();
        chk({tag, "_vld"}, 64'(v32), 64'd1);
        chk({tag, "_res"}, 64'(r32), 64'(exp));
        step();
        chk({tag, "_once"}, 64'(v32), 64'd0);
    endtask

    // Behavioural reference: full 128-bit signed product of the extended operands.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o, input int w);
        logic signed [127:0] ae, be, p;
        logic [63:0] m;
        logic as, bs, hi;
`ifdef NIOS2_MULT_HIGH_WORD_EN
        as = o[1]; bs = (o == 2'b11); hi = (o != 2'b00);
`else
        as = 1'b0; bs = 1'b0; hi = 1'b0;
`endif
        ae = '0; be = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < w) begin
                ae[i] = a[i];
                be[i] = b[i];
            end else begin
                ae[i] = as & a[w-1];
                be[i] = bs & b[w-1];
            end
        end
        p = ae * be;
        if (hi) p = p >>> w;
        m = (64'd1 << w) - 64'd1;
        return 32'(p[63:0] & m);
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;

        step();
        step();
        chk("rst_res", 64'(r32), 64'd0);
        chk("rst_vld", 64'(v32), 64'd0);
        reset_n = 1'b1;

        run1("mul_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001);
`ifdef NIOS2_MULT_HIGH_WORD_EN
        run1("mulxuu", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE);
        run1("mulxss", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000000);
        run1("mulxss_min", 32'h80000000, 32'h80000000, 2'b11, 32'h40000000);
        run1("mulxsu", 32'hFFFFFFFF, 32'h00000002, 2'b10, 32'hFFFFFFFF);
`else
        run1("off_op11", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h00000001);
        run1("off_op01", 32'h80000000, 32'h80000000, 2'b01, 32'h00000000);
        run1("off_op10", 32'hFFFFFFFF, 32'h00000002, 2'b10, 32'hFFFFFFFE);
`endif

        // Back-to-back stream with a 3-cycle stall after the second op
        src1 = 3; src2 = 5; op = 2'b00; vld = 1'b1;
        step();
        src1 = 7; src2 = 11;
        step();
        chk("st_r0", 64'(r32), 64'd15);
        chk("st_v0", 64'(v32), 64'd1);
        en = 1'b0; src1 = 13; src2 = 17;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_r", 64'(r32), 64'd15);
            chk("st_hold_v", 64'(v32), 64'd1);
        end
        en = 1'b1;
        step();
        vld = 1'b0;
        chk("st_r1", 64'(r32), 64'd77);
        chk("st_v1", 64'(v32), 64'd1);
        step();
        chk("st_r2", 64'(r32), 64'd221);
        chk("st_v2", 64'(v32), 64'd1);
        step();
        chk("st_end", 64'(v32), 64'd0);

        // Flush with a new op on the same edge
        issue(2, 3, 2'b00);
        issue(4, 5, 2'b00);
        chk("fl_pre", 64'(r32), 64'd6);
        src1 = 6; src2 = 7; vld = 1'b1; flush = 1'b1;
        step();
        vld = 1'b0; flush = 1'b0;
        chk("fl_v0", 64'(v32), 64'd0);
        step();
        chk("fl_v1", 64'(v32), 64'd0);
        step();
        chk("fl_v2", 64'(v32), 64'd0);

        // Flush while stalled still clears the in-flight op
        issue(8, 9, 2'b00);
        en = 1'b0; flush = 1'b1;
        step();
        chk("fls_v0", 64'(v32), 64'd0);
        en = 1'b1; flush = 1'b0;
        step();
        chk("fls_v1", 64'(v32), 64'd0);

        // Asynchronous reset with two ops in flight
        issue(10, 11, 2'b00);
        issue(12, 13, 2'b00);
        chk("rm_pre", 64'(r32), 64'd110);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_res", 64'(r32), 64'd0);
        chk("rm_vld", 64'(v32), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("rm_post0", 64'(v32), 64'd0);
        step();
        chk("rm_post1", 64'(v32), 64'd0);
        run1("rm_first", 3, 4, 2'b00, 32'd12);

        // Width sweep: corner operands then random ones, all ops
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
                1: begin a = 32'h80808080; b = 32'h80808080; end
                2: begin a = 32'h7F7F7FFF; b = 32'h80008080; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            o = 2'(i % 4);
            issue(a, b, o);
            step();
            chk("sw32", 64'(r32), 64'(model(a, b, o, 32)));
            chk("sw16", 64'(r16), 64'(model(a, b, o, 16)));
            chk("sw8",  64'(r8),  64'(model(a, b, o, 8)));
            chk("sw_v", 64'({v32, v16, v8}), 64'd7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
